display_scan_controller: RTL and testbench

Time-multiplexes one shared bcd_to_7seg decoder across NUM_DIGITS common-cathode/anode digits of the clock display (HH:MM:SS). Scans the digits in order, inserting a blanking gap between digits to suppress ghosting. Captures the BCD digit vector once per frame so a time update never tears mid-frame. Drives the decoder's bcd/en inputs and the one-hot digit select lines.

---
 rtl/display_scan_controller.sv | 139 +++++++++++++
 tb/tb_display_scan_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// Multiplexes one shared 7-segment decoder across NUM_DIGITS digits with a
// blanking gap at the start of every digit slot and a per-frame digit shadow.
module display_scan_controller #(
  parameter int NUM_DIGITS   = 6,
  parameter int DIGIT_CYCLES = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en,
  input  logic                    lzb_en,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  output logic [3:0]              bcd_out,
  output logic                    dec_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_start
);

  localparam int CNT_W = $clog2(DIGIT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST       = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BLANK,
    S_SHOW
  } state_t;

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [3:0]              r_bcd;
  logic                    r_dec_en;
  logic [NUM_DIGITS-1:0]   r_sel;
  logic                    r_frame_start;

  logic [3:0]              w_cur_digit;
  logic [3:0]              w_next_digit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_show_en;

  always_comb begin
    w_cur_digit  = '0;
    w_next_digit = '0;
    w_onehot     = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_digit  = r_shadow[4*i +: 4];
        w_next_digit = r_shadow[4*((i + 1) % NUM_DIGITS) +: 4];
        w_onehot[i]  = 1'b1;
      end
    end
    // lzb_en is used live so blanking follows the switch without a frame delay
    w_show_en = !(lzb_en && (r_idx == IDX_LAST) && (w_cur_digit == 4'd0));
  end

  // Outputs are assigned alongside the transition that selects the next state,
  // so each registered output already matches the state it is shown in.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_bcd         <= '0;
      r_dec_en      <= 1'b0;
      r_sel         <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (!en) begin
        r_state  <= S_IDLE;
        r_cnt    <= '0;
        r_idx    <= '0;
        r_bcd    <= '0;
        r_dec_en <= 1'b0;
        r_sel    <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_state       <= S_BLANK;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow      <= digits_bcd;
            r_bcd         <= digits_bcd[3:0];
            r_dec_en      <= 1'b0;
            r_sel         <= '0;
            r_frame_start <= 1'b1;
          end
          S_BLANK: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_BLANK_LAST) begin
              r_state  <= S_SHOW;
              r_sel    <= w_onehot;
              r_dec_en <= w_show_en;
            end
          end
          S_SHOW: begin
            if (r_cnt == CNT_SLOT_LAST) begin
              r_state  <= S_BLANK;
              r_cnt    <= '0;
              r_sel    <= '0;
              r_dec_en <= 1'b0;
              if (r_idx == IDX_LAST) begin
                r_idx         <= '0;
                r_shadow      <= digits_bcd;
                r_bcd         <= digits_bcd[3:0];
                r_frame_start <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
                r_bcd <= w_next_digit;
              end
            end else begin
              r_cnt    <= r_cnt + 1'b1;
              r_dec_en <= w_show_en;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_bcd    <= '0;
            r_dec_en <= 1'b0;
            r_sel    <= '0;
          end
        endcase
      end
    end
  end

  assign bcd_out     = r_bcd;
  assign dec_en      = r_dec_en;
  assign digit_sel   = r_sel;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: a frame-time model predicts every output cycle, a monitor
// compares and also checks select overlap, blank gaps and frame period.
module tb_display_scan_controller;

  localparam int N  = 6;
  localparam int DC = 8;
  localparam int BC = 2;

  logic            clk;
  logic            reset_n;
  logic            en;
  logic            lzb_en;
  logic [4*N-1:0]  digits_bcd;
  logic [3:0]      bcd_out;
  logic            dec_en;
  logic [N-1:0]    digit_sel;
  logic            frame_start;

  typedef struct packed {
    logic         active;
    logic         fs;
    logic [N-1:0] sel;
    logic         dec;
    logic [3:0]   bcd;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  display_scan_controller #(
    .NUM_DIGITS  (N),
    .DIGIT_CYCLES(DC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .en         (en),
    .lzb_en     (lzb_en),
    .digits_bcd (digits_bcd),
    .bcd_out    (bcd_out),
    .dec_en     (dec_en),
    .digit_sel  (digit_sel),
    .frame_start(frame_start)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs from the position t within the frame.
  function automatic exp_t ref_out(bit act, int t, logic [4*N-1:0] sh, logic lzb);
    exp_t e;
    int slot;
    int pos;
    logic [4*N-1:0] tmp;
    e = '0;
    if (act) begin
      slot     = t / DC;
      pos      = t % DC;
      tmp      = sh >> (4 * slot);
      e.active = 1'b1;
      e.fs     = (t == 0);
      e.bcd    = tmp[3:0];
      if (pos >= BC) begin
        e.sel = N'(1 << slot);
        e.dec = !(lzb && (slot == N - 1) && (tmp[3:0] == 4'd0));
      end
    end
    return e;
  endfunction

  initial begin
    bit             active;
    int             t;
    logic [4*N-1:0] shadow;
    active = 1'b0;
    t      = 0;
    shadow = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        active = 1'b0;
        if (clk === 1'b1) sb_q.push_back('0);
      end else begin
        if (!en) begin
          active = 1'b0;
        end else if (!active) begin
          active = 1'b1;
          t      = 0;
          shadow = digits_bcd;
        end else begin
          t++;
          if (t == N * DC) begin
            t      = 0;
            shadow = digits_bcd;
          end
        end
        sb_q.push_back(ref_out(active, t, shadow, lzb_en));
      end
    end
  end

  initial begin
    exp_t         e;
    int           cyc;
    int           prev_fs;
    int           zero_run;
    logic [N-1:0] prev_sel;
    bit           seen_sel;
    bit           prev_rst;
    cyc = 0; prev_fs = -1; zero_run = 0; prev_sel = '0; seen_sel = 0; prev_rst = 0;
    forever begin
      @(negedge clk or negedge reset_n);
      if (!reset_n && prev_rst) begin
        #1;
        checks++;
        if ({bcd_out, dec_en, digit_sel, frame_start} !== '0) begin
          failures++;
          $display("FAIL async_reset: bcd=%0h dec=%0b sel=%b fs=%0b, required all 0",
                   bcd_out, dec_en, digit_sel, frame_start);
        end
        prev_fs  = -1;
        prev_rst = 1'b0;
      end else begin
        prev_rst = reset_n;
        if (clk == 1'b0 && sb_q.size() > 0) begin
          e = sb_q.pop_front();
          cyc++;
          checks++;
          if (bcd_out !== e.bcd || dec_en !== e.dec || digit_sel !== e.sel ||
              frame_start !== e.fs) begin
            failures++;
            $display("FAIL scoreboard cyc=%0d: got bcd=%0h dec=%0b sel=%b fs=%0b, required bcd=%0h dec=%0b sel=%b fs=%0b",
                     cyc, bcd_out, dec_en, digit_sel, frame_start, e.bcd, e.dec, e.sel, e.fs);
          end
          checks++;
          if ($countones(digit_sel) > 1) begin
            failures++;
            $display("FAIL onehot cyc=%0d: sel=%b, required at most one bit", cyc, digit_sel);
          end
          if (digit_sel != '0) begin
            if (prev_sel != '0) begin
              checks++;
              if (digit_sel != prev_sel) begin
                failures++;
                $display("FAIL gap cyc=%0d: sel %b -> %b with 0 blank cycles, required >= %0d",
                         cyc, prev_sel, digit_sel, BC);
              end
            end else if (seen_sel) begin
              checks++;
              if (zero_run < BC) begin
                failures++;
                $display("FAIL gap cyc=%0d: blank run %0d, required >= %0d", cyc, zero_run, BC);
              end
            end
            seen_sel = 1'b1;
            zero_run = 0;
          end else begin
            zero_run++;
          end
          prev_sel = digit_sel;
          if (!e.active) prev_fs = -1;
          if (frame_start === 1'b1) begin
            if (prev_fs >= 0) begin
              checks++;
              if (cyc - prev_fs != N * DC) begin
                failures++;
                $display("FAIL frame_period cyc=%0d: got %0d, required %0d",
                         cyc, cyc - prev_fs, N * DC);
              end
            end
            prev_fs = cyc;
          end
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic async_reset_pulse();
    @(negedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    cycles(1);
  endtask

  initial begin
    int unsigned act;
    logic [4*N-1:0] d;
    reset_n    = 1'b0;
    en         = 1'b0;
    lzb_en     = 1'b0;
    digits_bcd = 24'h123456;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    en = 1'b1;
    cycles(1 + 2 * N * DC);
    cycles(20);
    digits_bcd = 24'h999999;
    cycles(28 + N * DC);

    digits_bcd = 24'h012345;
    lzb_en     = 1'b1;
    cycles(2 * N * DC);
    lzb_en = 1'b0;
    cycles(2 * N * DC);

    en = 1'b0;
    cycles(2);
    en = 1'b1;
    cycles(1 + 3 * DC + 3);
    en = 1'b0;
    cycles(3);
    en = 1'b1;
    cycles(60);

    digits_bcd = 24'h123456;
    cycles(10);
    async_reset_pulse();
    cycles(N * DC + 10);

    for (int k = 0; k < 40; k++) begin
      act = $urandom_range(0, 9);
      if (act == 0) begin
        en = 1'b0;
        cycles($urandom_range(1, 5));
        en = 1'b1;
      end else if (act == 1) begin
        async_reset_pulse();
      end else begin
        d = 24'($urandom);
        if ($urandom_range(0, 1) == 1) d[4*N-1 -: 4] = 4'd0;
        digits_bcd = d;
        lzb_en     = 1'($urandom_range(0, 1));
        cycles($urandom_range(5, 60));
      end
    end
    cycles(2 * N * DC);

    en = 1'b0;
    cycles(3);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
